mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: a two-requester, round-robin arbitrated shift-add multiplier.
//
// Requester 0 (CPU) and requester 1 (logic analyzer) share one sequential
// unsigned multiplier. A winner is picked in IDLE and its operands are captured.
// RUN then performs one LSB-first shift-add step per cycle. DONE presents the
// full 2*WIDTH-bit product and pulses the winner's done for one cycle.
//
// Optional feature: define MUL_EARLY_TERM_EN to let RUN exit as soon as the
// remaining multiplier bits are all zero. The minimum is one RUN cycle. The
// product is the same in both builds.
//
// Handshake: a requester raises req with its operands and holds them stable
// while req is high. gnt is high from capture until the edge that leaves DONE.
// done is a single-cycle pulse in DONE that marks product valid. Requests that
// appear or vanish during RUN/DONE are not queued. A req that is still high in
// IDLE counts as a fresh request.
//
// fsm_state exposes the controller state for checkers: 0=IDLE, 1=RUN, 2=DONE.

module mul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [1:0]         fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  // Operation context
  logic               owner;        // requester that owns the current operation
  logic               last_served;  // requester captured most recently
  logic [2*WIDTH-1:0] mcand;        // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier;       // multiplier, shifted right each step
  logic [2*WIDTH-1:0] acc;          // partial product
  logic [CW-1:0]      cnt;          // RUN steps completed
  logic [2*WIDTH-1:0] product_q;

  // Arbitration and step helpers
  logic               any_req;
  logic               pick;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_step;
  logic               last_step;
  logic               capture;

  // Round-robin pick: a lone request wins, and a tie goes to whoever was not
  // served last.
  always_comb begin
    any_req = req0 | req1;
    pick    = 1'b0;
    if (req0 && req1) begin
      pick = ~last_served;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  // One shift-add step computed from the current context.
  always_comb begin
    addend      = mplier[0] ? mcand : '0;
    acc_step    = acc + addend;
    mplier_step = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
    last_step   = (cnt == CW'(WIDTH - 1)) || (mplier_step == '0);
`else
    last_step   = (cnt == CW'(WIDTH - 1));
`endif
  end

  assign capture = (state == S_IDLE) && any_req;

  // State register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (any_req) state_next = S_RUN;
      S_RUN:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on grant, one shift-add per RUN cycle, latch the
  // result on the way into DONE.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      product_q   <= '0;
    end else if (capture) begin
      owner       <= pick;
      last_served <= pick;
      mcand       <= {{WIDTH{1'b0}}, (pick ? a1 : a0)};
      mplier      <= pick ? b1 : b0;
      acc         <= '0;
      cnt         <= '0;
    end else if (state == S_RUN) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier_step;
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        product_q <= acc_step;
      end
    end
  end

  // Outputs are decoded from state and owner, so reset clears them at once.
  always_comb begin
    busy      = (state != S_IDLE);
    gnt0      = busy && (owner == 1'b0);
    gnt1      = busy && (owner == 1'b1);
    done0     = (state == S_DONE) && (owner == 1'b0);
    done1     = (state == S_DONE) && (owner == 1'b1);
    product   = product_q;
    fsm_state = state;
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed scenarios plus randomized operations for
// mul_seq_ctrl. Expected values come from plain arithmetic (a*b), a round-robin
// model, and a latency rule derived from the multiplier's bit length.
// The bench honours MUL_EARLY_TERM_EN the same way the design does.

module tb_mul_seq_ctrl;

  localparam int W = 8;

  // Clock and reset
  logic           clock = 1'b0;
  logic           resetb;
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, done0, done1, busy;
  logic [2*W-1:0] product;
  logic [1:0]     fsm_state;

  always #5 clock = ~clock;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .product   (product),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // Scoreboard state
  int             n_tests = 0;
  int             n_fail  = 0;
  logic [2*W-1:0] exp_q[$];
  bit             ls_model;   // requester served last, per the round-robin model

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: number of RUN cycles for a given multiplier.
  function automatic int run_len(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int n;
    logic [W-1:0] v;
    n = 0;
    v = b;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    return (n == 0) ? 1 : n;
`else
    return W;
`endif
  endfunction

  function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    return (2*W)'(x) * (2*W)'(y);
  endfunction

  // Reference model: round-robin arbitration.
  task automatic arbitrate(input bit r0, input bit r1, output int win);
    if (r0 && r1) win = ls_model ? 0 : 1;
    else          win = r1 ? 1 : 0;
    ls_model = (win == 1);
  endtask

  // Driver tasks
  task automatic drive_req(input int who, input logic [W-1:0] x, input logic [W-1:0] y);
    if (who == 0) begin a0 = x; b0 = y; req0 = 1'b1; end
    else          begin a1 = x; b1 = y; req1 = 1'b1; end
  endtask

  // Follow one operation from grant to done and check it. The winner's req
  // drops when its done is seen. idle_wait counts negedges until gnt appears.
  task automatic serve(input int win, input logic [2*W-1:0] exp_prod, input int exp_run,
                       input string tag, output int idle_wait);
    int cyc;
    bit seen;
    logic [2*W-1:0] want;
    exp_q.push_back(exp_prod);
    seen = 1'b0;
    idle_wait = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      idle_wait++;
      if (gnt0 | gnt1) seen = 1'b1;
    end
    check({tag, "_grant_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      void'(exp_q.pop_front());
      return;
    end
    check({tag, "_gnt0"}, 32'(gnt0), 32'(win == 0));
    check({tag, "_gnt1"}, 32'(gnt1), 32'(win == 1));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 1;
    seen = done0 | done1;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      check({tag, "_loser_gnt"}, 32'(win == 0 ? gnt1 : gnt0), 32'd0);
      seen = done0 | done1;
    end
    want = exp_q.pop_front();
    check({tag, "_latency"}, 32'(cyc), 32'(exp_run + 1));
    check({tag, "_done0"}, 32'(done0), 32'(win == 0));
    check({tag, "_done1"}, 32'(done1), 32'(win == 1));
    check({tag, "_product"}, 32'(product), 32'(want));
    if (win == 0) req0 = 1'b0;
    else          req1 = 1'b0;
    @(negedge clock);
    check({tag, "_done_single"}, 32'(done0 | done1), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_product_held"}, 32'(product), 32'(want));
  endtask

  // Stimulus sequence
  initial begin
    int w, w2, iw, mode;
    logic [W-1:0] x0, y0, x1, y1;
    bit seen;

    resetb = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    ls_model = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("reset_done", 32'({done0, done1}), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_state", 32'(fsm_state), 32'd0);
    resetb = 1'b1;

    // Scenario 3: simultaneous requests after reset, both held until own done.
    drive_req(0, 8'd3, 8'd4);
    drive_req(1, 8'd5, 8'd6);
    arbitrate(1, 1, w);
    check("s3_first_winner_model", 32'(w), 32'd0);
    serve(w, mul_ref(8'd3, 8'd4), run_len(8'd4), "s3_first", iw);
    arbitrate(0, 1, w2);
    serve(w2, mul_ref(8'd5, 8'd6), run_len(8'd6), "s3_second", iw);
    check("s3_second_owner", 32'(w2), 32'd1);
    check("s3_idle_gap", 32'(iw), 32'd1);

    // Scenario 1 with perturbation: operands change, req0 drops and req1
    // pulses during RUN. None of this may disturb the operation or queue.
    drive_req(0, 8'd13, 8'd11);
    arbitrate(1, 0, w);
    fork
      serve(w, 16'h008F, run_len(8'd11), "s1", iw);
      begin
        repeat (3) @(negedge clock);
        a0 = 8'($urandom_range(0, 255));
        b0 = 8'($urandom_range(0, 255));
        req0 = 1'b0;
        a1 = 8'd99; b1 = 8'd77; req1 = 1'b1;
        @(negedge clock);
        req1 = 1'b0;
      end
    join
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("s1_no_queued_gnt", 32'(gnt0 | gnt1), 32'd0);
    end

    // Scenario 2: maximum operands from requester 1.
    drive_req(1, 8'd255, 8'd255);
    arbitrate(0, 1, w);
    serve(w, 16'hFE01, run_len(8'd255), "s2", iw);

    // Scenario 5: zero multiplier and a lone MSB.
    drive_req(0, 8'd57, 8'd0);
    arbitrate(1, 0, w);
    serve(w, 16'h0000, run_len(8'd0), "s5_zero", iw);
    drive_req(0, 8'd2, 8'h80);
    arbitrate(1, 0, w);
    serve(w, 16'h0100, run_len(8'h80), "s5_msb", iw);

    // Randomized operations: one requester or both at once.
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 2);
      x0 = 8'($urandom_range(0, 255)); y0 = 8'($urandom_range(0, 255));
      x1 = 8'($urandom_range(0, 255)); y1 = 8'($urandom_range(0, 255));
      if (n == 0) begin y0 = 8'd1; y1 = 8'd0; end
      if (mode != 1) drive_req(0, x0, y0);
      if (mode != 0) drive_req(1, x1, y1);
      arbitrate(mode != 1, mode != 0, w);
      serve(w, (w == 0) ? mul_ref(x0, y0) : mul_ref(x1, y1),
            run_len((w == 0) ? y0 : y1), "rand", iw);
      if (mode == 2) begin
        arbitrate(w == 1, w == 0, w2);
        serve(w2, (w2 == 0) ? mul_ref(x0, y0) : mul_ref(x1, y1),
              run_len((w2 == 0) ? y0 : y1), "rand_tie2", iw);
      end
    end

    // Scenario 4: reset three cycles into RUN of 200*100.
    drive_req(0, 8'd200, 8'd100);
    arbitrate(1, 0, w);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (gnt0 | gnt1) seen = 1'b1;
    end
    check("s4_grant_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clock);
    #2 resetb = 1'b0;
    #1;
    check("s4_rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("s4_rst_done", 32'({done0, done1}), 32'd0);
    check("s4_rst_busy", 32'(busy), 32'd0);
    check("s4_rst_product", 32'(product), 32'd0);
    check("s4_rst_state", 32'(fsm_state), 32'd0);
    req0 = 1'b0;
    ls_model = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("s4_no_done", 32'(done0 | done1), 32'd0);
    end
    resetb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("s4_lost_op", 32'(done0 | done1 | busy), 32'd0);
    end
    drive_req(0, 8'd7, 8'd9);
    arbitrate(1, 0, w);
    serve(w, 16'd63, run_len(8'd9), "s4_after", iw);

    // Tie right after reset goes to requester 0.
    resetb = 1'b0;
    ls_model = 1'b1;
    @(negedge clock);
    resetb = 1'b1;
    drive_req(0, 8'd10, 8'd10);
    drive_req(1, 8'd20, 8'd20);
    arbitrate(1, 1, w);
    serve(w, mul_ref(8'd10, 8'd10), run_len(8'd10), "tie_rst_a", iw);
    arbitrate(0, 1, w2);
    serve(w2, mul_ref(8'd20, 8'd20), run_len(8'd20), "tie_rst_b", iw);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

endmodule
